rps_score_keeper: RTL
=====================

Name: rps_score_keeper

Overview:
Match controller for the rock-paper-scissors game. It collects one choice per player per round and judges each round. It keeps both players' scores and drives num1/num2 straight into the two-digit seven-segment display stage downstream. It also runs the match state machine: start, round collection, result hold, and game over.

Parameters:
WIN_SCORE, 3, score that ends the match; legal range 1..9.
SHOW_CYCLES, 1000, clock cycles the round result is held before the next round opens; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse; clears scores and begins a new match.
p1_valid  input  1  single-cycle pulse; p1_choice is valid.
p1_choice  input  2  00 none, 01 rock, 10 paper, 11 scissors.
p2_valid  input  1  single-cycle pulse; p2_choice is valid.
p2_choice  input  2  same encoding as p1_choice.
num1  output  4  player-1 score, BCD 0..9, to display digit 1.
num2  output  4  player-2 score, BCD 0..9, to display digit 2.
round_result  output  2  00 none, 01 p1 won, 10 p2 won, 11 tie.
busy  output  1  high while a round result is being held (SHOW).
game_over  output  1  high in OVER.
winner  output  2  00 none, 01 p1, 10 p2; valid while game_over is high.

Behaviour:
- Reset (async, rst=1): state IDLE; num1, num2, round_result, winner, busy, game_over all 0; choice locks cleared; hold counter 0.
- All outputs are registered.
- States: IDLE, COLLECT, SHOW, OVER.
- start has priority over every other input, in any state. On the next edge: scores = 0, locks cleared, round_result = 00, winner = 00, hold counter = 0, state = COLLECT.
- IDLE: waits for start only. Valid pulses are ignored.
- COLLECT, latching choices:
  - p1_valid with p1_choice != 00 latches the choice and sets lock1, but only if lock1 is clear.
  - Later p1 pulses are ignored until the round ends.
  - A pulse with choice 00 is ignored.
  - Player 2 behaves identically with lock2.
  - Both players may latch in the same cycle.
- COLLECT, judging:
  - On the first edge where lock1 and lock2 are both already set, the round is judged and state goes to SHOW.
  - Latency: the later latch happens on edge N; scores and round_result update on edge N+1.
  - Rules: rock beats scissors, scissors beats paper, paper beats rock. Equal choices are a tie.
  - The winner's score increments by 1 and saturates at 9. A tie changes neither score.
- SHOW:
  - busy = 1; valid inputs are ignored.
  - The hold counter counts 0..SHOW_CYCLES-1.
  - On the edge where the counter equals SHOW_CYCLES-1:
    - If num1 == WIN_SCORE: state = OVER, winner = 01.
    - Else if num2 == WIN_SCORE: state = OVER, winner = 10.
    - Otherwise: state = COLLECT, locks cleared, round_result = 00, counter = 0.
  - busy drops on that same edge.
- OVER:
  - game_over = 1; scores, winner, and the last round_result are held.
  - Only start or rst leaves OVER.
- Both scores cannot reach WIN_SCORE together, because each round increments at most one score.
- Reset mid-round: all state is lost immediately; no partial score is kept.
- start during SHOW: the hold is aborted and the match restarts as described above.
- Counter width is $clog2(SHOW_CYCLES+1). SHOW_CYCLES=1 gives exactly one SHOW cycle.

Test Plan:
- Reset, then start; p1 rock (01), p2 scissors (11) in the same cycle → one edge later num1=1, num2=0, round_result=01, busy=1 for SHOW_CYCLES=4 cycles, then round_result=00 and state COLLECT.
- p1 paper at cycle 10, second p1 pulse rock at cycle 12, p2 paper at cycle 15 → tie: round_result=11, scores unchanged; the second p1 pulse has no effect.
- p2 wins three rounds with WIN_SCORE=3 (scissors vs paper) → num2=3; after hold, game_over=1, winner=10; further valid pulses leave all outputs unchanged.
- Valid pulses with choice 00, and pulses while in IDLE or SHOW → no lock, no score change.
- start asserted during SHOW with score 2-1 → next edge num1=0, num2=0, busy=0, round_result=00, state COLLECT.
- rst asserted asynchronously mid-clock during COLLECT with p1 locked → outputs clear immediately, before the next clk edge; the subsequent p2 pulse alone does not score.

Source files
------------

// File: rtl/rps_score_keeper.sv
// rps_score_keeper: rock-paper-scissors match controller that latches both players' choices,
// judges each round, keeps BCD scores for the display and sequences start/collect/show/over.
module rps_score_keeper #(
    parameter int WIN_SCORE   = 3,
    parameter int SHOW_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p1_valid,
    input  logic [1:0] p1_choice,
    input  logic       p2_valid,
    input  logic [1:0] p2_choice,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [1:0] round_result,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int CW = $clog2(SHOW_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SHOW, OVER} state_t;

    state_t          state_q, state_d;
    logic [3:0]      num1_q, num1_d, num2_q, num2_d;
    logic [1:0]      rr_q, rr_d, win_q, win_d, c1_q, c1_d, c2_q, c2_d;
    logic            lock1_q, lock1_d, lock2_q, lock2_d;
    logic            busy_q, busy_d, over_q, over_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            p1_wins, hold_done;

    // 01 rock, 10 paper, 11 scissors: each beats the one it cyclically follows
    assign p1_wins   = (c1_q == 2'd1 && c2_q == 2'd3) ||
                       (c1_q == 2'd3 && c2_q == 2'd2) ||
                       (c1_q == 2'd2 && c2_q == 2'd1);
    assign hold_done = cnt_q == CW'(SHOW_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        rr_d    = rr_q;
        win_d   = win_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        lock1_d = lock1_q;
        lock2_d = lock2_q;
        busy_d  = busy_q;
        over_d  = over_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = COLLECT;
            num1_d  = '0;
            num2_d  = '0;
            rr_d    = '0;
            win_d   = '0;
            lock1_d = 1'b0;
            lock2_d = 1'b0;
            busy_d  = 1'b0;
            over_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (lock1_q && lock2_q) begin
                        state_d = SHOW;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        if (c1_q == c2_q) begin
                            rr_d = 2'b11;
                        end else if (p1_wins) begin
                            rr_d   = 2'b01;
                            num1_d = (num1_q == 4'd9) ? num1_q : num1_q + 4'd1;
                        end else begin
                            rr_d   = 2'b10;
                            num2_d = (num2_q == 4'd9) ? num2_q : num2_q + 4'd1;
                        end
                    end else begin
                        if (p1_valid && p1_choice != 2'b00 && !lock1_q) begin
                            c1_d    = p1_choice;
                            lock1_d = 1'b1;
                        end
                        if (p2_valid && p2_choice != 2'b00 && !lock2_q) begin
                            c2_d    = p2_choice;
                            lock2_d = 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (hold_done) begin
                        busy_d = 1'b0;
                        if (num1_q == 4'(WIN_SCORE)) begin
                            state_d = OVER;
                            win_d   = 2'b01;
                            over_d  = 1'b1;
                        end else if (num2_q == 4'(WIN_SCORE)) begin
                            state_d = OVER;
                            win_d   = 2'b10;
                            over_d  = 1'b1;
                        end else begin
                            state_d = COLLECT;
                            lock1_d = 1'b0;
                            lock2_d = 1'b0;
                            rr_d    = '0;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num1_q  <= '0;
            num2_q  <= '0;
            rr_q    <= '0;
            win_q   <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            lock1_q <= 1'b0;
            lock2_q <= 1'b0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            lock1_q <= lock1_d;
            lock2_q <= lock2_d;
            busy_q  <= busy_d;
            over_q  <= over_d;
            cnt_q   <= cnt_d;
        end
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign round_result = rr_q;
    assign winner       = win_q;
    assign busy         = busy_q;
    assign game_over    = over_q;
endmodule
